// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-way round-robin arbiter with held, registered one-hot grant.
// Define ARB_HOLD_LIMIT_EN to cap tenure at HOLD_MAX cycles when others wait.
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, nxt_state;
    logic [1:0] idx_q, nxt_idx;
    logic [1:0] last_idx, nxt_last;
    logic [2:0] srch;

    // Reject configurations whose counter cannot reach the limit
    if (HOLD_MAX < 2 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cfg
        $error("rr_arbiter_4: need HOLD_MAX>=2 and 2**CNT_W>HOLD_MAX");
    end

    // First set bit scanning base+1 .. base+4; returns {hit, index}
    function automatic logic [2:0] pick(input logic [1:0] base,
                                        input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] j;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            j = base + 2'(k);
            if (r[j]) res = {1'b1, j};
        end
        return res;
    endfunction

`ifdef ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hold_cnt, nxt_cnt;
    logic [3:0]       others;
    logic             at_limit;

    assign others   = req & ~(4'b0001 << idx_q);
    assign at_limit = (hold_cnt == CNT_W'(HOLD_MAX - 1));

    // Tenure counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_cnt <= '0;
        else        hold_cnt <= nxt_cnt;
    end
`endif

    // State, owner and rotation pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx_q    <= 2'd0;
            last_idx <= 2'd3;
        end else begin
            state    <= nxt_state;
            idx_q    <= nxt_idx;
            last_idx <= nxt_last;
        end
    end

    // Next-state: grant on request, hand over on release or forced rotation
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx_q;
        nxt_last  = last_idx;
        srch      = 3'b000;
`ifdef ARB_HOLD_LIMIT_EN
        nxt_cnt   = hold_cnt;
`endif
        unique case (state)
            IDLE: begin
                srch = pick(last_idx, req);
                if (srch[2]) begin
                    nxt_state = GRANT;
                    nxt_idx   = srch[1:0];
                    nxt_last  = srch[1:0];
`ifdef ARB_HOLD_LIMIT_EN
                    nxt_cnt   = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    srch = pick(idx_q, req);
                    if (srch[2]) begin
                        nxt_idx  = srch[1:0];
                        nxt_last = srch[1:0];
                    end else begin
                        nxt_state = IDLE;
                        nxt_idx   = 2'd0;
                    end
`ifdef ARB_HOLD_LIMIT_EN
                    nxt_cnt = '0;
                end else if (at_limit && |others) begin
                    srch     = pick(idx_q, others);
                    nxt_idx  = srch[1:0];
                    nxt_last = srch[1:0];
                    nxt_cnt  = '0;
                end else if (!at_limit) begin
                    nxt_cnt = hold_cnt + CNT_W'(1);
`endif
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_idx   = 2'd0;
            end
        endcase
    end

    assign gnt_valid = (state == GRANT);
    assign gnt_idx   = gnt_valid ? idx_q : 2'd0;
    assign gnt       = gnt_valid ? (4'b0001 << idx_q) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed vectors for the round-robin arbiter.
// Expected values are hand-derived; hold-limit checks follow ARB_HOLD_LIMIT_EN.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_chk = 0;
    int n_err = 0;

    rr_arbiter_4 #(.HOLD_MAX(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [1:0] i);
        logic [3:0] eg;
        logic [1:0] ei;
        eg = v ? (4'b0001 << i) : 4'b0000;
        ei = v ? i : 2'd0;
        chk({tag, ".gnt"}, {4'b0, gnt}, {4'b0, eg});
        chk({tag, ".idx"}, {6'b0, gnt_idx}, {6'b0, ei});
        chk({tag, ".vld"}, {7'b0, gnt_valid}, {7'b0, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int e;
        logic lim;
`ifdef ARB_HOLD_LIMIT_EN
        lim = 1'b1;
`else
        lim = 1'b0;
`endif
        rst_n = 1'b0;
        req   = 4'b0000;
        #2;
        chk_out("rst", 1'b0, 2'd0);
        reset_dut();

        // idle with no requests
        for (int c = 0; c < 5; c++) begin
            step();
            chk_out("idle", 1'b0, 2'd0);
        end

        // all requesting, each owner releases after 2 cycles
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            e = i % 4;
            step();
            chk_out($sformatf("rot%0d.a", i), 1'b1, 2'(e));
            req = 4'b1111;
            step();
            chk_out($sformatf("rot%0d.b", i), 1'b1, 2'(e));
            req = ~(4'b0001 << e);
        end
        step();
        chk_out("rot.last", 1'b1, 2'd1);
        req = 4'b0000;
        step();
        chk_out("rot.idle", 1'b0, 2'd0);

        // release with simultaneous new requests
        req = 4'b0100;
        step();
        chk_out("sw.own2", 1'b1, 2'd2);
        req = 4'b1001;
        step();
        chk_out("sw.own3", 1'b1, 2'd3);
        req = 4'b0001;
        step();
        chk_out("sw.own0", 1'b1, 2'd0);
        req = 4'b0000;
        step();
        chk_out("sw.idle", 1'b0, 2'd0);

        // two constant requesters: hold limit or unbounded hold
        reset_dut();
        req = 4'b0011;
        for (int c = 0; c < 24; c++) begin
            step();
            e = lim ? (c / 8) % 2 : 0;
            chk_out($sformatf("hold%0d", c), 1'b1, 2'(e));
        end
        req = 4'b0000;
        step();
        chk_out("hold.idle", 1'b0, 2'd0);

        // lone requester keeps grant, mid-cycle glitches ignored
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) begin
                req = 4'b0000;
                #2 req = 4'b0010;
            end
            step();
            chk_out($sformatf("solo%0d", c), 1'b1, 2'd1);
        end

        // async reset mid-grant, rotation restarts at 0
        req = 4'b0000;
        step();
        chk_out("pre6.idle", 1'b0, 2'd0);
        req = 4'b0100;
        step();
        chk_out("r6.own2", 1'b1, 2'd2);
        req = 4'b1100;
        step();
        chk_out("r6.hold", 1'b1, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_out("r6.async", 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_out("r6.restart", 1'b1, 2'd2);
        req = 4'b1000;
        step();
        chk_out("r6.next3", 1'b1, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
